// File: rtl/cam_pkg.sv
// Shared state encoding and default frame geometry for the camera frame-capture block.
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cam_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int WIN_DEF      = 256;

    // Buffer address of the bottom-right window pixel; 16'hFFFF for a 256-pixel window.
    function automatic logic [15:0] last_addr(input int win);
        return {8'(win - 1), 8'(win - 1)};
    endfunction

endpackage

// File: rtl/capture_window.sv
// Combinational window test: decides whether pixel (h, v) lies inside the latched
// capture window and forms its buffer address {row, col} relative to the window corner.
module capture_window
    import cam_pkg::*;
#(
    parameter int WIN = WIN_DEF
) (
    input  logic [9:0]  h,
    input  logic [8:0]  v,
    input  logic [9:0]  wx,
    input  logic [8:0]  wy,
    output logic        hit,
    output logic [15:0] addr
);

    localparam logic [10:0] WIN_H = 11'(WIN);
    localparam logic [9:0]  WIN_V = 10'(WIN);

    logic [10:0] h_end;
    logic [9:0]  v_end;

    always_comb begin
        h_end = {1'b0, wx} + WIN_H;
        v_end = {1'b0, wy} + WIN_V;
        hit   = (h >= wx) && ({1'b0, h} < h_end) && (v >= wy) && ({1'b0, v} < v_end);
        // Offsets are only meaningful modulo 256 since the window edge is at most 256.
        addr  = {v[7:0] - wy[7:0], h[7:0] - wx[7:0]};
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Camera frame-capture controller: tracks the raster position of incoming pixels and
// writes a square window of each captured frame into a buffer, single-shot or continuous.
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int WIN      = WIN_DEF
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        frame_start,
    input  logic        frame_done,
    input  logic        cont_mode,
    input  logic        capture_req,
    input  logic [9:0]  win_x,
    input  logic [8:0]  win_y,
    output logic        buf_we,
    output logic [15:0] buf_waddr,
    output logic [15:0] buf_wdata,
    output logic        frame_ready,
    output logic        busy,
    output logic        short_frame,
    output logic [1:0]  state_o
);

    localparam logic [9:0]  H_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  V_END     = 9'(V_ACTIVE);
    localparam logic [9:0]  WX_MAX    = 10'(H_ACTIVE - WIN);
    localparam logic [8:0]  WY_MAX    = 9'(V_ACTIVE - WIN);
    localparam logic [15:0] LAST_ADDR = last_addr(WIN);

    cam_state_e  state_q, state_d;
    logic [9:0]  h_q, h_d;
    logic [8:0]  v_q, v_d;
    logic [9:0]  wx_q, wx_d;
    logic [8:0]  wy_q, wy_d;
    logic        we_q, we_d;
    logic [15:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        short_q, short_d;
    logic        last_wr_q, last_wr_d;

    logic        relatch;
    logic        counting;
    logic        pix_take;
    logic [9:0]  cur_h;
    logic [8:0]  cur_v;
    logic [9:0]  cur_wx;
    logic [8:0]  cur_wy;
    logic        win_hit;
    logic [15:0] win_addr;

    // A frame start (on arming, or restarting mid-capture) positions any coincident
    // pixel at (0,0) against the freshly clamped window.
    always_comb begin
        relatch  = ((state_q == ST_ARM) && frame_start) ||
                   ((state_q == ST_CAPTURE) && frame_start && !frame_done);
        counting = ((state_q == ST_ARM) && frame_start) || (state_q == ST_CAPTURE);
        cur_h    = relatch ? 10'd0 : h_q;
        cur_v    = relatch ? 9'd0 : v_q;
        cur_wx   = relatch ? ((win_x > WX_MAX) ? WX_MAX : win_x) : wx_q;
        cur_wy   = relatch ? ((win_y > WY_MAX) ? WY_MAX : win_y) : wy_q;
        pix_take = counting && pix_valid && (cur_v < V_END);
    end

    capture_window #(.WIN(WIN)) u_window (
        .h    (cur_h),
        .v    (cur_v),
        .wx   (cur_wx),
        .wy   (cur_wy),
        .hit  (win_hit),
        .addr (win_addr)
    );

    always_comb begin
        h_d  = cur_h;
        v_d  = cur_v;
        wx_d = cur_wx;
        wy_d = cur_wy;
        if (pix_take) begin
            if (cur_h == H_LAST) begin
                h_d = 10'd0;
                v_d = cur_v + 9'd1;
            end else begin
                h_d = cur_h + 10'd1;
            end
        end

        we_d    = pix_take && win_hit;
        waddr_d = we_d ? win_addr : waddr_q;
        wdata_d = we_d ? pix_data : wdata_q;

        last_wr_d = relatch ? 1'b0 : last_wr_q;
        if (we_d && (win_addr == LAST_ADDR)) begin
            last_wr_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        short_d = short_q;
        unique case (state_q)
            ST_IDLE: begin
                if (capture_req) begin
                    short_d = 1'b0;
                end
                if (cont_mode || capture_req) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (frame_start) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (frame_done) begin
                    state_d = ST_DONE;
                    // v_d already includes a pixel arriving with frame_done.
                    ready_d = last_wr_d;
                    if (v_d != V_END) begin
                        short_d = 1'b1;
                    end
                end else if (frame_start) begin
                    short_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = cont_mode ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            h_q       <= 10'd0;
            v_q       <= 9'd0;
            wx_q      <= 10'd0;
            wy_q      <= 9'd0;
            we_q      <= 1'b0;
            waddr_q   <= 16'd0;
            wdata_q   <= 16'd0;
            ready_q   <= 1'b0;
            short_q   <= 1'b0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            wx_q      <= wx_d;
            wy_q      <= wy_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            short_q   <= short_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign buf_we      = we_q;
    assign buf_waddr   = waddr_q;
    assign buf_wdata   = wdata_q;
    assign frame_ready = ready_q;
    assign short_frame = short_q;
    assign busy        = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl on a reduced 16x12 raster with an 8x8 window.
module tb_frame_capture_ctrl;

    localparam int H = 16;
    localparam int V = 12;
    localparam int W = 8;

    logic        clk_50      = 1'b0;
    logic        rst_n       = 1'b0;
    logic        pix_valid   = 1'b0;
    logic [15:0] pix_data    = 16'd0;
    logic        frame_start = 1'b0;
    logic        frame_done  = 1'b0;
    logic        cont_mode   = 1'b0;
    logic        capture_req = 1'b0;
    logic [9:0]  win_x       = 10'd0;
    logic [8:0]  win_y       = 9'd0;
    logic        buf_we;
    logic [15:0] buf_waddr;
    logic [15:0] buf_wdata;
    logic        frame_ready;
    logic        busy;
    logic        short_frame;
    logic [1:0]  state_o;

    always #5 clk_50 = ~clk_50;

    frame_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .WIN(W)) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .cont_mode   (cont_mode),
        .capture_req (capture_req),
        .win_x       (win_x),
        .win_y       (win_y),
        .buf_we      (buf_we),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .frame_ready (frame_ready),
        .busy        (busy),
        .short_frame (short_frame),
        .state_o     (state_o)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          ready_cnt = 0;
    int          wr_cnt    = 0;
    logic [31:0] first_wr  = 32'd0;
    logic [31:0] last_wr   = 32'd0;
    logic [31:0] mon_got;
    logic [31:0] exp_q[$];

    typedef struct {
        int win_x;
        int win_y;
        int lines;
        bit start_pix;
        bit done_last;
        int exp_wx;
        int exp_wy;
        int exp_ready;
        bit exp_short;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] pd(input int h, input int v);
        return 16'(4096 + v * 32 + h);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    always @(negedge clk_50) begin
        if (rst_n) begin
            if (buf_we) begin
                mon_got = {buf_waddr, buf_wdata};
                if (wr_cnt == 0) first_wr = mon_got;
                last_wr = mon_got;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got %h expected no write", mon_got);
                end else begin
                    check("write", mon_got, exp_q.pop_front());
                end
            end
            if (frame_ready) ready_cnt++;
        end
    end

    task automatic arm_single();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    // Expects the DUT in ARM; fills the scoreboard from the window present at frame start.
    task automatic run_frame(input int lines, input bit start_pix, input bit done_last,
                             input int mid_wx);
        int wx, wy, n, idx;
        wx = (int'(win_x) > H - W) ? H - W : int'(win_x);
        wy = (int'(win_y) > V - W) ? V - W : int'(win_y);
        for (int v = 0; v < lines; v++)
            for (int h = 0; h < H; h++)
                if (h >= wx && h < wx + W && v >= wy && v < wy + W)
                    exp_q.push_back({8'(v - wy), 8'(h - wx), pd(h, v)});
        wr_cnt   = 0;
        first_wr = 32'd0;
        last_wr  = 32'd0;
        pix_valid = 1'b1;
        pix_data  = 16'hDEAD;
        tick();
        pix_valid = 1'b0;
        n   = lines * H;
        idx = 0;
        frame_start = 1'b1;
        if (start_pix) begin
            pix_valid = 1'b1;
            pix_data  = pd(0, 0);
            idx = 1;
        end
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        while (idx < n) begin
            repeat ($urandom_range(0, 1)) tick();
            if (mid_wx >= 0 && idx == n / 2) win_x = 10'(mid_wx);
            pix_valid = 1'b1;
            pix_data  = pd(idx % H, idx / H);
            if (done_last && idx == n - 1) frame_done = 1'b1;
            tick();
            pix_valid  = 1'b0;
            frame_done = 1'b0;
            idx++;
        end
        if (!done_last) begin
            repeat ($urandom_range(0, 2)) tick();
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
        end
        repeat (3) tick();
    endtask

    initial begin
        vecs[0] = '{0,   0,   V,  1'b1, 1'b1, 0, 0, 1, 1'b0};
        vecs[1] = '{500, 300, V,  1'b1, 1'b0, 8, 4, 1, 1'b0};
        vecs[2] = '{3,   2,   V,  1'b0, 1'b0, 3, 2, 1, 1'b0};
        vecs[3] = '{8,   4,   V,  1'b0, 1'b1, 8, 4, 1, 1'b0};
        vecs[4] = '{9,   5,   V,  1'b1, 1'b0, 8, 4, 1, 1'b0};
        vecs[5] = '{0,   0,   5,  1'b1, 1'b0, 0, 0, 0, 1'b1};
        vecs[6] = '{0,   0,   10, 1'b0, 1'b0, 0, 0, 1, 1'b1};
        vecs[7] = '{2,   6,   11, 1'b1, 1'b1, 2, 4, 0, 1'b1};

        #2;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(buf_we), 32'd0);
        check("rst_waddr", 32'(buf_waddr), 32'd0);
        check("rst_wdata", 32'(buf_wdata), 32'd0);
        check("rst_ready", 32'(frame_ready), 32'd0);
        check("rst_short", 32'(short_frame), 32'd0);
        #20 rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(state_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            win_x     = 10'(vecs[i].win_x);
            win_y     = 9'(vecs[i].win_y);
            cont_mode = 1'b0;
            arm_single();
            check("arm_state", 32'(state_o), 32'd1);
            check("arm_busy", 32'(busy), 32'd1);
            check("short_cleared", 32'(short_frame), 32'd0);
            ready_cnt = 0;
            run_frame(vecs[i].lines, vecs[i].start_pix, vecs[i].done_last, -1);
            check("writes_left", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            check("first_write", first_wr, {16'h0000, pd(vecs[i].exp_wx, vecs[i].exp_wy)});
            if (vecs[i].lines == V)
                check("last_write", last_wr,
                      {16'h0707, pd(vecs[i].exp_wx + W - 1, vecs[i].exp_wy + W - 1)});
            check("ready_count", 32'(ready_cnt), 32'(vecs[i].exp_ready));
            check("short_frame", 32'(short_frame), 32'(vecs[i].exp_short));
            check("end_idle", 32'(state_o), 32'd0);
            check("end_busy", 32'(busy), 32'd0);
        end

        // Continuous mode: window change during frame 2 lands only in frame 3.
        win_x = 10'd0;
        win_y = 9'd0;
        cont_mode = 1'b1;
        ready_cnt = 0;
        tick();
        check("cont_arm", 32'(state_o), 32'd1);
        run_frame(V, 1'b1, 1'b0, -1);
        check("cont_f1_arm", 32'(state_o), 32'd1);
        run_frame(V, 1'b1, 1'b0, 5);
        check("cont_f2_first", first_wr, {16'h0000, pd(0, 0)});
        cont_mode = 1'b0;
        tick();
        check("cont_mode_ignored_in_arm", 32'(state_o), 32'd1);
        run_frame(V, 1'b1, 1'b1, -1);
        check("cont_f3_first", first_wr, {16'h0000, pd(5, 0)});
        check("cont_ready_count", 32'(ready_cnt), 32'd3);
        check("cont_end_idle", 32'(state_o), 32'd0);
        check("cont_writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Reset in the middle of a capture, right after a window pixel was taken.
        win_x = 10'd0;
        win_y = 9'd0;
        arm_single();
        for (int h = 0; h < W; h++) exp_q.push_back({8'd0, 8'(h), pd(h, 0)});
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int h = 0; h < H; h++) begin
            pix_valid = 1'b1;
            pix_data  = pd(h, 0);
            tick();
            pix_valid = 1'b0;
        end
        pix_valid = 1'b1;
        pix_data  = pd(0, 1);
        @(posedge clk_50);
        #1;
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(buf_we), 32'd0);
        check("midrst_state", 32'(state_o), 32'd0);
        check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #10 rst_n = 1'b1;
        tick();
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_data    = pd(0, 0);
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pix_data = pd(k % H, k / H);
            tick();
        end
        pix_valid = 1'b0;
        tick();
        check("postrst_idle", 32'(state_o), 32'd0);
        arm_single();
        ready_cnt = 0;
        run_frame(V, 1'b1, 1'b0, -1);
        check("postrst_first", first_wr, {16'h0000, pd(0, 0)});
        check("postrst_ready", 32'(ready_cnt), 32'd1);
        check("postrst_writes_left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, lines per frame; WIN, default 256, capture window edge in pixels.
REQ-002 SHALL have ports (name  direction  width  meaning), with one clock: clk_50 (posedge) and rst_n (asynchronous, active-low).
- clk_50  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  one-cycle strobe, pixel present on pix_data (already synchronised to clk_50)
- pix_data  in  16  RGB565 pixel
- frame_start  in  1  one-cycle pulse, start of camera frame
- frame_done  in  1  one-cycle pulse, end of camera frame
- cont_mode  in  1  1 = continuous capture, 0 = single-shot
- capture_req  in  1  one-cycle pulse, arms one capture in single-shot mode
- win_x  in  10  window left column
- win_y  in  9  window top line
- buf_we  out  1  buffer write enable
- buf_waddr  out  16  buffer address {row[7:0], col[7:0]}
- buf_wdata  out  16  buffer write data
- frame_ready  out  1  one-cycle pulse, full window written
- busy  out  1  high in ARM or CAPTURE
- short_frame  out  1  sticky, frame ended before H_ACTIVE*V_ACTIVE pixels
- state_o  out  2  current state, for debug LEDs

Function
REQ-003 SHALL implement FSM with states IDLE=0, ARM=1, CAPTURE=2, DONE=3.
REQ-004 SHALL go IDLE->ARM when cont_mode=1, or when capture_req=1 in the same cycle.
REQ-005 SHALL go ARM->CAPTURE on frame_start, and SHALL ignore pix_valid while in ARM.
REQ-006 SHALL, on the ARM->CAPTURE edge, latch wx=min(win_x, H_ACTIVE-WIN) and wy=min(win_y, V_ACTIVE-WIN); the latched window SHALL stay constant until the next ARM->CAPTURE.
REQ-007 SHALL, in CAPTURE, keep column counter h (10b) and line counter v (9b): each pix_valid increments h; at h==H_ACTIVE-1, h returns to 0 and v increments; pixels with v>=V_ACTIVE SHALL be dropped and the counters SHALL saturate.
REQ-008 SHALL, when frame_start and pix_valid arrive in the same cycle as ARM->CAPTURE, count that pixel as (h=0, v=0).
REQ-009 SHALL assert buf_we for exactly one cycle, the cycle after pix_valid, when wx<=h<wx+WIN and wy<=v<wy+WIN, with buf_waddr={(v-wy)[7:0], (h-wx)[7:0]} and buf_wdata=pix_data; write latency SHALL be 1 cycle.
REQ-010 SHALL hold buf_waddr and buf_wdata when buf_we=0.
REQ-011 SHALL go CAPTURE->DONE on frame_done; if frame_done and pix_valid arrive in the same cycle, the pixel SHALL be written first.
REQ-012 SHALL set short_frame if frame_done arrives before the last pixel (h=H_ACTIVE-1, v=V_ACTIVE-1); short_frame SHALL clear only on reset or capture_req.
REQ-013 SHALL assert frame_ready for one cycle on CAPTURE->DONE only if the window's last address 0xFFFF was written; otherwise no pulse.
REQ-014 SHALL, in DONE, go to ARM next cycle if cont_mode=1, otherwise to IDLE; cont_mode SHALL be sampled only in IDLE and DONE.
REQ-015 SHALL ignore capture_req in ARM, CAPTURE and DONE.
REQ-016 SHALL, on frame_start in CAPTURE (no preceding frame_done), set short_frame, reset counters and relatch the window, staying in CAPTURE.
REQ-017 SHALL drive busy=(state==ARM || state==CAPTURE) and state_o=state combinationally.

Reset
REQ-018 SHALL, on rst_n=0, asynchronously set state=IDLE, h=0, v=0, wx=0, wy=0, buf_we=0, buf_waddr=0, buf_wdata=0, frame_ready=0, short_frame=0.
REQ-019 SHALL, on reset mid-CAPTURE, deassert buf_we immediately; after release the FSM SHALL wait in IDLE/ARM for a fresh frame_start.

Structure
REQ-020 SHALL place the state encoding and the H_ACTIVE/V_ACTIVE/WIN defaults in shared package cam_pkg.
REQ-021 SHALL be one module, with the window hit/address computation in sub-module capture_window (combinational; inputs h, v, wx, wy; outputs hit, addr).

Verification
REQ-022 Single-shot, window (0,0), full 640x480 frame -> 65536 writes, first addr 0x0000 = pixel (0,0), last 0xFFFF = pixel (255,255); frame_ready pulse; state returns to IDLE.
REQ-023 win_x=500, win_y=300 -> clamped to (384,224); pixel (384,224) written at 0x0000, pixel (639,479) at 0xFFFF.
REQ-024 frame_done after 100 lines -> short_frame=1, no frame_ready, DONE->IDLE.
REQ-025 cont_mode=1, three frames -> three frame_ready pulses; win_x changed mid-frame 2 takes effect only in frame 3.
REQ-026 rst_n low at pixel 1000 of CAPTURE -> buf_we=0 within the same cycle; after release, no writes until capture_req and then frame_start.
REQ-027 frame_start coincident with pix_valid on arming -> that pixel is written at 0x0000.
